hit_resolver: RTL and testbench
===============================

# hit_resolver

Combat referee sitting between the two player FSMs. Each game tick it checks active attack hitboxes against the opponent's main hurtbox, decides hit vs. block, and drives each player's `hitFlag`, `health` and `block` inputs. It also owns the round-end (KO) state machine.

## Interface
- `HEALTH_INIT`, default 5: health loaded on reset and restart (3-bit, 1..7).
- `BLOCK_INIT`, default 3: block meter loaded on reset and restart (3-bit).
- `DMG_BASIC`, default 1: health lost per unblocked basic hit.
- `DMG_DIR`, default 2: health lost per unblocked directional hit.
- `REGEN_TICKS`, default 120: ticks per +1 block regeneration. Only used when `HIT_RESOLVER_BLOCK_REGEN_EN` is defined.
- `clk`  in  1  game tick clock, one per frame.
- `rst`  in  1  reset, synchronous, active-high.
- `restart`  in  1  one-tick pulse that starts a new round. Honoured only in `S_KO`.
- `p1_state`, `p2_state`  in  4 each  player FSM `current_state`.
- `p1_basic_box`, `p1_dir_box`, `p1_hurt_box`, and the same three for p2  in  40 each  packed `{x1,x2,y1,y2}`, 10 bits per field, x1 in bits [39:30].
- `p1_hit_flag`, `p2_hit_flag`  out  2 each  codes: 00 none, 01 basic, 10 directional.
- `p1_health`, `p2_health`  out  3 each  remaining health.
- `p1_block`, `p2_block`  out  3 each  remaining block meter.
- `game_over`  out  1  high while in `S_KO`.
- `winner`  out  2  01 = p1 won, 10 = p2 won, 11 = double KO, 00 = no result yet.

## Operation
- **Overlap test:** inclusive on all four edges. A overlaps B when `A.x1<=B.x2 && B.x1<=A.x2 && A.y1<=B.y2 && B.y1<=A.y2`.
- **Active windows:**
  - Attacker in `S_B_ATTACK_END` (4): its basic box is tested against the defender's hurt box.
  - Attacker in `S_D_ATTACK_END` (7): its directional box is tested.
  - No other state produces hits.
- **One-hit latch (per attacker):**
  - A detection counts only while the attacker's latch is clear.
  - Any counted detection sets the latch.
  - The latch clears on the first tick the attacker is not in state 4 or 7.
- **Defender in `S_HITSTUN` (9) or `S_BLOCKSTUN` (10):** the hit is consumed. The latch is set, but there is no flag and no meter change.
- **Block:** defender in `S_MOVEBACKWARDS` (2) with `block>0`.
  - `block` decrements by 1 and `health` is unchanged.
  - The flag is still driven (01 or 10), because the player FSM chooses blockstun itself.
- **Unblocked hit:** `health` decreases by `DMG_BASIC` or `DMG_DIR`, saturating at 0.
- **Trades:** both players hitting in the same tick are processed independently. Both meters update and both flags assert.
- **Round FSM:**
  - `S_FIGHT`: normal processing. Enters `S_KO` on the tick after any `health` reaches 0.
  - `winner` is set at the `S_KO` entry edge from which players reached 0 (both at 0 → 11).
  - `S_KO`: hits are ignored, flags stay 00, meters hold, `game_over`=1.
  - `S_KO` + `restart`: return to `S_FIGHT`. Reload meters, clear latches, regen counters and `winner`.
- **Reset:** state `S_FIGHT`; health=`HEALTH_INIT`; block=`BLOCK_INIT`; flags 00; `game_over` 0; `winner` 00; latches and regen counters 0.

## Timing
- Detection is combinational on tick N inputs.
- Flag, health, block and latch are all registered at the N→N+1 edge.
- Each flag is a one-tick pulse, valid during tick N+1 only.
- A held overlap produces exactly one pulse per attack instance.
- `game_over` rises one tick after the health register reads 0, i.e. two ticks after the killing detection.
- `rst` has priority over `restart` and over every update, including mid-round and during `S_KO`.

## Configuration
- **`HIT_RESOLVER_BLOCK_REGEN_EN` defined:**
  - Each player has a counter that advances in `S_FIGHT` while `block<BLOCK_INIT`.
  - The counter resets to 0 on any block event for that player.
  - At `REGEN_TICKS-1` the counter wraps to 0 and `block` increments by 1, never exceeding `BLOCK_INIT`.
  - A block event on the same tick wins: decrement, no increment.
- **Undefined:** `block` only decreases. It is restored only by `rst` or `restart`; counters and `REGEN_TICKS` are absent.

## Structure
- **`game_pkg`:**
  - Player state encodings 0..10 (shared with the player FSM).
  - Hit-flag codes.
  - Box field slice constants.
  - Round-state enum (`S_FIGHT`, `S_KO`).
  - Winner codes.
- **`box_overlap`:** combinational sub-module, two 40-bit boxes in, 1-bit overlap out. Instantiated four times.

## Test plan
- **Basic hit:** p1 state 4, p1 basic `{135,213,194,227}` overlapping p2 hurt `{200,250,170,320}`, p2 idle, held 3 ticks → `p2_hit_flag`=01 for exactly one tick, `p2_health` 5→4.
- **Block:** p2 state 2, block=3, p1 state 7 overlapping → flag 10 once, `p2_block` 3→2, health stays 5.
- **Trade:** both in state 4 overlapping each other → both flags 01 on the same tick, both health 5→4.
- **KO:** p2 health 1, p1 directional hit → health 0 (saturates, not 7). Two ticks after detection `game_over`=1, `winner`=01. Further overlaps give no flags. `restart` → meters 5/3, `winner` 00.
- **Stun immunity:** p2 in state 9, p1 state 4 overlapping → no flag, no change. p1 stays in state 4 while p2 returns to 0 → still no hit (latch set).
- **Regen** (macro on, `REGEN_TICKS`=4): block 2, no events → 3 after 4 ticks, then holds. `rst` mid-count → block 3, counter 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the fighting-game core: player FSM states, hit codes,
// box field slices, round states and winner codes.
package game_pkg;

  localparam logic [3:0] S_IDLE          = 4'd0;
  localparam logic [3:0] S_MOVEFORWARDS  = 4'd1;
  localparam logic [3:0] S_MOVEBACKWARDS = 4'd2;
  localparam logic [3:0] S_B_ATTACK_START = 4'd3;
  localparam logic [3:0] S_B_ATTACK_END  = 4'd4;
  localparam logic [3:0] S_B_ATTACK_PULL = 4'd5;
  localparam logic [3:0] S_D_ATTACK_START = 4'd6;
  localparam logic [3:0] S_D_ATTACK_END  = 4'd7;
  localparam logic [3:0] S_D_ATTACK_PULL = 4'd8;
  localparam logic [3:0] S_HITSTUN       = 4'd9;
  localparam logic [3:0] S_BLOCKSTUN     = 4'd10;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BASIC = 2'b01;
  localparam logic [1:0] HIT_DIR   = 2'b10;

  // Boxes are packed {x1,x2,y1,y2}, 10 bits each, x1 in the top field.
  localparam int X1_HI = 39;
  localparam int X1_LO = 30;
  localparam int X2_HI = 29;
  localparam int X2_LO = 20;
  localparam int Y1_HI = 19;
  localparam int Y1_LO = 10;
  localparam int Y2_HI = 9;
  localparam int Y2_LO = 0;

  typedef enum logic [0:0] {
    S_FIGHT = 1'b0,
    S_KO    = 1'b1
  } round_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/box_overlap.sv
// Inclusive axis-aligned rectangle overlap test between two packed boxes.
module box_overlap
  import game_pkg::*;
(
  input  logic [39:0] box_a,
  input  logic [39:0] box_b,
  output logic        overlap
);

  logic [9:0] ax1, ax2, ay1, ay2;
  logic [9:0] bx1, bx2, by1, by2;

  assign ax1 = box_a[X1_HI:X1_LO];
  assign ax2 = box_a[X2_HI:X2_LO];
  assign ay1 = box_a[Y1_HI:Y1_LO];
  assign ay2 = box_a[Y2_HI:Y2_LO];
  assign bx1 = box_b[X1_HI:X1_LO];
  assign bx2 = box_b[X2_HI:X2_LO];
  assign by1 = box_b[Y1_HI:Y1_LO];
  assign by2 = box_b[Y2_HI:Y2_LO];

  assign overlap = (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/hit_resolver.sv
// Combat referee: resolves hits/blocks between two players and runs the KO round FSM.
// Optional block-meter regeneration is enabled by defining HIT_RESOLVER_BLOCK_REGEN_EN.
module hit_resolver
  import game_pkg::*;
#(
  parameter logic [2:0] HEALTH_INIT = 3'd5,
  parameter logic [2:0] BLOCK_INIT  = 3'd3,
  parameter logic [2:0] DMG_BASIC   = 3'd1,
  parameter logic [2:0] DMG_DIR     = 3'd2
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
  ,
  parameter int         REGEN_TICKS = 120
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [3:0]  p1_state,
  input  logic [3:0]  p2_state,
  input  logic [39:0] p1_basic_box,
  input  logic [39:0] p1_dir_box,
  input  logic [39:0] p1_hurt_box,
  input  logic [39:0] p2_basic_box,
  input  logic [39:0] p2_dir_box,
  input  logic [39:0] p2_hurt_box,
  output logic [1:0]  p1_hit_flag,
  output logic [1:0]  p2_hit_flag,
  output logic [2:0]  p1_health,
  output logic [2:0]  p2_health,
  output logic [2:0]  p1_block,
  output logic [2:0]  p2_block,
  output logic        game_over,
  output logic [1:0]  winner
);

  // Index 0 = player 1, index 1 = player 2 throughout.
  logic [1:0][3:0]  st;
  logic [1:0][39:0] basic_box, dir_box, hurt_box;

  assign st        = {p2_state, p1_state};
  assign basic_box = {p2_basic_box, p1_basic_box};
  assign dir_box   = {p2_dir_box, p1_dir_box};
  assign hurt_box  = {p2_hurt_box, p1_hurt_box};

  round_state_t     round_q, round_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       latch_q, latch_d;
  logic [1:0][1:0]  flag_q, flag_d;
  logic [1:0][2:0]  health_q, health_d;
  logic [1:0][2:0]  block_q, block_d;

  logic [1:0] ov_basic, ov_dir, in_window, counted;
  logic [1:0] stunned, blocking, block_evt;
  logic [1:0][1:0] hit_code;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      // gi as attacker: its boxes against the opponent's hurt box.
      box_overlap u_basic (
        .box_a   (basic_box[gi]),
        .box_b   (hurt_box[1-gi]),
        .overlap (ov_basic[gi])
      );
      box_overlap u_dir (
        .box_a   (dir_box[gi]),
        .box_b   (hurt_box[1-gi]),
        .overlap (ov_dir[gi])
      );

      assign in_window[gi] = (st[gi] == S_B_ATTACK_END) || (st[gi] == S_D_ATTACK_END);
      assign hit_code[gi]  = (st[gi] == S_B_ATTACK_END) ? HIT_BASIC : HIT_DIR;
      assign counted[gi]   = (round_q == S_FIGHT) && !latch_q[gi] &&
                             (((st[gi] == S_B_ATTACK_END) && ov_basic[gi]) ||
                              ((st[gi] == S_D_ATTACK_END) && ov_dir[gi]));

      // gi as defender.
      assign stunned[gi]   = (st[gi] == S_HITSTUN) || (st[gi] == S_BLOCKSTUN);
      assign blocking[gi]  = (st[gi] == S_MOVEBACKWARDS) && (block_q[gi] != 3'd0);
      assign block_evt[gi] = counted[1-gi] && !stunned[gi] && blocking[gi];
    end
  endgenerate

`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
  localparam int CW = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;
  logic [1:0][CW-1:0] regen_q, regen_d;
`endif

  always_comb begin
    round_d  = round_q;
    winner_d = winner_q;
    latch_d  = latch_q;
    flag_d   = '0;
    health_d = health_q;
    block_d  = block_q;
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
    regen_d  = regen_q;
`endif
    if (round_q == S_KO) begin
      for (int a = 0; a < 2; a++) begin
        latch_d[a] = in_window[a] ? latch_q[a] : 1'b0;
      end
      if (restart) begin
        round_d  = S_FIGHT;
        winner_d = WIN_NONE;
        latch_d  = '0;
        health_d = {HEALTH_INIT, HEALTH_INIT};
        block_d  = {BLOCK_INIT, BLOCK_INIT};
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
        regen_d  = '0;
`endif
      end
    end else begin
      for (int a = 0; a < 2; a++) begin
        latch_d[a] = in_window[a] ? (latch_q[a] | counted[a]) : 1'b0;
        // A stunned defender swallows the hit: latch set, nothing else changes.
        if (counted[a] && !stunned[1-a]) begin
          flag_d[1-a] = hit_code[a];
          if (blocking[1-a]) begin
            block_d[1-a] = block_q[1-a] - 3'd1;
          end else if (hit_code[a] == HIT_BASIC) begin
            health_d[1-a] = (health_q[1-a] < DMG_BASIC) ? 3'd0 : health_q[1-a] - DMG_BASIC;
          end else begin
            health_d[1-a] = (health_q[1-a] < DMG_DIR) ? 3'd0 : health_q[1-a] - DMG_DIR;
          end
        end
      end
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
      for (int p = 0; p < 2; p++) begin
        if (block_evt[p]) begin
          regen_d[p] = '0;
        end else if (block_q[p] < BLOCK_INIT) begin
          if (regen_q[p] == CW'(REGEN_TICKS - 1)) begin
            regen_d[p] = '0;
            block_d[p] = block_q[p] + 3'd1;
          end else begin
            regen_d[p] = regen_q[p] + 1'b1;
          end
        end else begin
          regen_d[p] = '0;
        end
      end
`endif
      if ((health_q[0] == 3'd0) || (health_q[1] == 3'd0)) begin
        round_d  = S_KO;
        winner_d = {health_q[0] == 3'd0, health_q[1] == 3'd0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q  <= S_FIGHT;
      winner_q <= WIN_NONE;
      latch_q  <= '0;
      flag_q   <= '0;
      health_q <= {HEALTH_INIT, HEALTH_INIT};
      block_q  <= {BLOCK_INIT, BLOCK_INIT};
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
      regen_q  <= '0;
`endif
    end else begin
      round_q  <= round_d;
      winner_q <= winner_d;
      latch_q  <= latch_d;
      flag_q   <= flag_d;
      health_q <= health_d;
      block_q  <= block_d;
`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
      regen_q  <= regen_d;
`endif
    end
  end

  assign p1_hit_flag = flag_q[0];
  assign p2_hit_flag = flag_q[1];
  assign p1_health   = health_q[0];
  assign p2_health   = health_q[1];
  assign p1_block    = block_q[0];
  assign p2_block    = block_q[1];
  assign game_over   = (round_q == S_KO);
  assign winner      = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed self-checking bench for hit_resolver (hits, blocks, trades, stun, KO, regen).
module tb_hit_resolver;

    logic        clk = 1'b0;
    logic        rst, restart;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_basic_box, p1_dir_box, p1_hurt_box;
    logic [39:0] p2_basic_box, p2_dir_box, p2_hurt_box;
    logic [1:0]  p1_hit_flag, p2_hit_flag;
    logic [2:0]  p1_health, p2_health, p1_block, p2_block;
    logic        game_over;
    logic [1:0]  winner;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
    hit_resolver #(.REGEN_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .p1_state     (p1_state),
        .p2_state     (p2_state),
        .p1_basic_box (p1_basic_box),
        .p1_dir_box   (p1_dir_box),
        .p1_hurt_box  (p1_hurt_box),
        .p2_basic_box (p2_basic_box),
        .p2_dir_box   (p2_dir_box),
        .p2_hurt_box  (p2_hurt_box),
        .p1_hit_flag  (p1_hit_flag),
        .p2_hit_flag  (p2_hit_flag),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .p1_block     (p1_block),
        .p2_block     (p2_block),
        .game_over    (game_over),
        .winner       (winner)
    );
`else
    hit_resolver dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .p1_state     (p1_state),
        .p2_state     (p2_state),
        .p1_basic_box (p1_basic_box),
        .p1_dir_box   (p1_dir_box),
        .p1_hurt_box  (p1_hurt_box),
        .p2_basic_box (p2_basic_box),
        .p2_dir_box   (p2_dir_box),
        .p2_hurt_box  (p2_hurt_box),
        .p1_hit_flag  (p1_hit_flag),
        .p2_hit_flag  (p2_hit_flag),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .p1_block     (p1_block),
        .p2_block     (p2_block),
        .game_over    (game_over),
        .winner       (winner)
    );
`endif

    function automatic logic [39:0] box(input int x1, input int x2, input int y1, input int y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        p1_state = 4'd0;
        p2_state = 4'd0;
        p1_basic_box = box(135, 213, 194, 227);
        p1_dir_box   = box(190, 260, 160, 200);
        p1_hurt_box  = box(100, 180, 150, 300);
        p2_basic_box = box(150, 210, 200, 240);
        p2_dir_box   = box(900, 950, 900, 950);
        p2_hurt_box  = box(200, 250, 170, 320);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_p1_health", p1_health, 5);
        chk("rst_p2_health", p2_health, 5);
        chk("rst_p2_block", p2_block, 3);
        chk("rst_flags", {p1_hit_flag, p2_hit_flag}, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);

        // Basic hit held for three ticks: one pulse only
        p1_state = 4'd4;
        tick();
        chk("basic_flag", p2_hit_flag, 1);
        chk("basic_health", p2_health, 4);
        tick();
        chk("basic_flag_held", p2_hit_flag, 0);
        tick();
        chk("basic_flag_held2", p2_hit_flag, 0);
        chk("basic_health2", p2_health, 4);
        chk("basic_p1_health", p1_health, 5);
        p1_state = 4'd0;
        tick();

        // Directional hit into a blocking defender
        p2_state = 4'd2;
        p1_state = 4'd7;
        tick();
        chk("block_flag", p2_hit_flag, 2);
        chk("block_meter", p2_block, 2);
        chk("block_health", p2_health, 4);
        tick();
        chk("block_flag_held", p2_hit_flag, 0);
        chk("block_meter2", p2_block, 2);
        p1_state = 4'd0;
        p2_state = 4'd0;
        tick();

        // Inclusive edge: x2 one short misses, x2 touching hits
        p1_basic_box = box(120, 199, 194, 227);
        p1_state = 4'd4;
        tick();
        chk("edge_miss_flag", p2_hit_flag, 0);
        chk("edge_miss_health", p2_health, 4);
        p1_basic_box = box(120, 200, 194, 227);
        tick();
        chk("edge_hit_flag", p2_hit_flag, 1);
        chk("edge_hit_health", p2_health, 3);
        p1_state = 4'd0;
        p1_basic_box = box(135, 213, 194, 227);
        tick();

        // Trade: both basic attacks land on the same tick
        p1_state = 4'd4;
        p2_state = 4'd4;
        tick();
        chk("trade_p1_flag", p1_hit_flag, 1);
        chk("trade_p2_flag", p2_hit_flag, 1);
        chk("trade_p1_health", p1_health, 4);
        chk("trade_p2_health", p2_health, 2);
        p1_state = 4'd0;
        p2_state = 4'd0;
        tick();

        // Hitstun consumes the hit; latch stays set after stun ends
        p2_state = 4'd9;
        p1_state = 4'd4;
        tick();
        chk("stun_flag", p2_hit_flag, 0);
        chk("stun_health", p2_health, 2);
        p2_state = 4'd0;
        tick();
        chk("stun_latch_flag", p2_hit_flag, 0);
        chk("stun_latch_health", p2_health, 2);
        p1_state = 4'd0;
        tick();

        // Bring p2 to 1, then a directional hit saturates at 0 and KOs
        p1_state = 4'd4;
        tick();
        chk("pre_ko_health", p2_health, 1);
        p1_state = 4'd0;
        tick();
        p1_state = 4'd7;
        tick();
        chk("ko_flag", p2_hit_flag, 2);
        chk("ko_health_sat", p2_health, 0);
        chk("ko_go_early", game_over, 0);
        tick();
        chk("ko_game_over", game_over, 1);
        chk("ko_winner", winner, 1);
        p1_state = 4'd0;
        tick();
        p1_state = 4'd4;
        tick();
        chk("ko_no_flag", p2_hit_flag, 0);
        chk("ko_hold_health", p2_health, 0);
        chk("ko_hold_go", game_over, 1);
        p1_state = 4'd0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_game_over", game_over, 0);
        chk("rs_winner", winner, 0);
        chk("rs_p1_health", p1_health, 5);
        chk("rs_p2_health", p2_health, 5);
        chk("rs_p2_block", p2_block, 3);

`ifdef HIT_RESOLVER_BLOCK_REGEN_EN
        // Regen: one block event, meter back to full four ticks later
        p2_state = 4'd2;
        p1_state = 4'd4;
        tick();
        chk("rg_block_evt", p2_block, 2);
        p1_state = 4'd0;
        p2_state = 4'd0;
        tick();
        tick();
        tick();
        chk("rg_not_yet", p2_block, 2);
        tick();
        chk("rg_regen", p2_block, 3);
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("rg_hold", p2_block, 3);
        p2_state = 4'd2;
        p1_state = 4'd4;
        tick();
        p1_state = 4'd0;
        p2_state = 4'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rg_rst_block", p2_block, 3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
